dcache: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache between the CPU load/store unit and the RAM interface module.
- 256 sets of 16-byte lines (4 × 32-bit words). CPU address is split into tag/index/offset.
- Misses write back a dirty victim line (128-bit burst) and then refill the line word-by-word from RAM.

---
 rtl/dcache_if.sv | 45 ++++
 rtl/dcache.sv | 244 ++++++++++++++++++++++++
 tb/tb_dcache.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// CPU load/store and RAM refill/writeback signals of the L1 data cache.
// The slave modport is the cache side; the master modport is the CPU/RAM side.
interface dcache_if #(
    parameter int CACHE_INDEX_AW  = 8,
    parameter int CACHE_TAG_WIDTH = 20,
    parameter int CACHE_OFFSET_AW = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int RAM_NUM         = 4,
    parameter int RV32_ADDR_WIDTH = 32
);
    logic                       cpu_req_i;
    logic                       cpu_op_i;
    logic [CACHE_INDEX_AW-1:0]  cpu_index_i;
    logic [CACHE_TAG_WIDTH-1:0] cpu_tag_i;
    logic [CACHE_OFFSET_AW-1:0] cpu_offset_i;
    logic [RAM_NUM-1:0]         cpu_wr_en_i;
    logic [DATA_WIDTH-1:0]      cpu_wr_data_i;
    logic [DATA_WIDTH-1:0]      cpu_rd_data_o;
    logic                       cpu_addr_ack_o;
    logic                       cpu_data_ack_o;
    logic                       ram_rd_req_o;
    logic [RV32_ADDR_WIDTH-1:0] ram_rd_addr_o;
    logic                       ram_rd_rdy_i;
    logic [DATA_WIDTH-1:0]      ram_rd_data_i;
    logic [2:0]                 ram_rd_num_i;
    logic                       ram_wr_rdy_i;
    logic                       ram_wr_req_o;
    logic [RV32_ADDR_WIDTH-1:0] ram_wr_addr_o;
    logic [DATA_WIDTH*4-1:0]    ram_wr_data_o;
    logic                       ram_dirty_o;

    modport slave (
        input  cpu_req_i, cpu_op_i, cpu_index_i, cpu_tag_i, cpu_offset_i, cpu_wr_en_i, cpu_wr_data_i,
        input  ram_rd_rdy_i, ram_rd_data_i, ram_rd_num_i, ram_wr_rdy_i,
        output cpu_rd_data_o, cpu_addr_ack_o, cpu_data_ack_o,
        output ram_rd_req_o, ram_rd_addr_o, ram_wr_req_o, ram_wr_addr_o, ram_wr_data_o, ram_dirty_o
    );

    modport master (
        output cpu_req_i, cpu_op_i, cpu_index_i, cpu_tag_i, cpu_offset_i, cpu_wr_en_i, cpu_wr_data_i,
        output ram_rd_rdy_i, ram_rd_data_i, ram_rd_num_i, ram_wr_rdy_i,
        input  cpu_rd_data_o, cpu_addr_ack_o, cpu_data_ack_o,
        input  ram_rd_req_o, ram_rd_addr_o, ram_wr_req_o, ram_wr_addr_o, ram_wr_data_o, ram_dirty_o
    );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache (256 sets x 16-byte lines).
// Define DCACHE_PERF_EN to add the hit_cnt_o / miss_cnt_o lookup counters.
module dcache #(
    parameter int CACHE_INDEX_AW  = 8,
    parameter int CACHE_TAG_WIDTH = 20,
    parameter int CACHE_OFFSET_AW = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int RAM_NUM         = 4,
    parameter int RV32_ADDR_WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    dcache_if.slave bus
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int SETS   = 1 << CACHE_INDEX_AW;
    localparam int LINE_W = DATA_WIDTH * 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_RESP      = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic                       op_q, op_d;
    logic [CACHE_INDEX_AW-1:0]  idx_q, idx_d;
    logic [CACHE_TAG_WIDTH-1:0] rtag_q, rtag_d;
    logic [1:0]                 word_q, word_d;
    logic [RAM_NUM-1:0]         wen_q, wen_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [LINE_W-1:0]          lbuf_q, lbuf_d;
    logic [SETS-1:0]            valid_q, valid_d;
    logic [SETS-1:0]            dirty_q, dirty_d;
    logic [LINE_W-1:0]          data_mem_q [SETS];
    logic [CACHE_TAG_WIDTH-1:0] tag_mem_q  [SETS];

    logic                       mem_we_s, tag_we_s, hit_s;
    logic [LINE_W-1:0]          mem_line_s, cur_line_s;
    logic                       addr_ack_s, data_ack_s, rd_req_s, wr_req_s, dirty_s;
    logic [DATA_WIDTH-1:0]      rd_data_s;
    logic [RV32_ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s;
    logic [LINE_W-1:0]          wr_data_s;
    logic                       unused_s;

    // Byte-lane merge of one word into a line; other words and lanes are untouched.
    function automatic logic [LINE_W-1:0] merge_line(
        input logic [LINE_W-1:0]     line,
        input logic [1:0]            sel,
        input logic [RAM_NUM-1:0]    be,
        input logic [DATA_WIDTH-1:0] wd
    );
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < RAM_NUM; b++) begin
            res[int'(sel) * DATA_WIDTH + b * 8 +: 8] =
                be[b] ? wd[b * 8 +: 8] : line[int'(sel) * DATA_WIDTH + b * 8 +: 8];
        end
        return res;
    endfunction

    assign cur_line_s = data_mem_q[idx_q];
    assign hit_s      = valid_q[idx_q] && (tag_mem_q[idx_q] == rtag_q);
    assign unused_s   = ^{bus.ram_rd_num_i[2], bus.cpu_offset_i[CACHE_OFFSET_AW-3:0]};

    // Next-state, request latch, array write controls and all cache outputs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        rtag_d     = rtag_q;
        word_d     = word_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        lbuf_d     = lbuf_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        mem_we_s   = 1'b0;
        tag_we_s   = 1'b0;
        mem_line_s = cur_line_s;
        addr_ack_s = 1'b0;
        data_ack_s = 1'b0;
        rd_data_s  = {DATA_WIDTH{1'b0}};
        rd_req_s   = 1'b0;
        rd_addr_s  = {RV32_ADDR_WIDTH{1'b0}};
        wr_req_s   = 1'b0;
        wr_addr_s  = {RV32_ADDR_WIDTH{1'b0}};
        wr_data_s  = {LINE_W{1'b0}};
        dirty_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_ack_s = bus.cpu_req_i;
                if (bus.cpu_req_i) begin
                    op_d    = bus.cpu_op_i;
                    idx_d   = bus.cpu_index_i;
                    rtag_d  = bus.cpu_tag_i;
                    word_d  = bus.cpu_offset_i[CACHE_OFFSET_AW-1 -: 2];
                    wen_d   = bus.cpu_wr_en_i;
                    wdata_d = bus.cpu_wr_data_i;
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP, ST_RESP: begin
                if ((state_q == ST_RESP) || hit_s) begin
                    data_ack_s = 1'b1;
                    state_d    = ST_IDLE;
                    if (op_q) begin
                        mem_we_s       = 1'b1;
                        mem_line_s     = merge_line(cur_line_s, word_q, wen_q, wdata_q);
                        dirty_d[idx_q] = 1'b1;
                    end else begin
                        rd_data_s = cur_line_s[int'(word_q) * DATA_WIDTH +: DATA_WIDTH];
                    end
                end else if (valid_q[idx_q] && dirty_q[idx_q]) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                wr_req_s  = 1'b1;
                dirty_s   = 1'b1;
                wr_addr_s = {tag_mem_q[idx_q], idx_q, {CACHE_OFFSET_AW{1'b0}}};
                wr_data_s = cur_line_s;
                if (bus.ram_wr_rdy_i) begin
                    state_d = ST_REFILL;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_REFILL: begin
                rd_req_s  = 1'b1;
                rd_addr_s = {rtag_q, idx_q, {CACHE_OFFSET_AW{1'b0}}};
                if (bus.ram_rd_rdy_i) begin
                    lbuf_d[int'(bus.ram_rd_num_i[1:0]) * DATA_WIDTH +: DATA_WIDTH] = bus.ram_rd_data_i;
                    // Word 3 closes the burst: install buffer, tag and clean-valid state together.
                    if (bus.ram_rd_num_i[1:0] == 2'd3) begin
                        mem_we_s       = 1'b1;
                        tag_we_s       = 1'b1;
                        mem_line_s     = lbuf_d;
                        valid_d[idx_q] = 1'b1;
                        dirty_d[idx_q] = 1'b0;
                        state_d        = ST_RESP;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end else begin
                    state_d = ST_REFILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state, request latch, line buffer and valid/dirty bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 1'b0;
            idx_q   <= {CACHE_INDEX_AW{1'b0}};
            rtag_q  <= {CACHE_TAG_WIDTH{1'b0}};
            word_q  <= 2'd0;
            wen_q   <= {RAM_NUM{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            lbuf_q  <= {LINE_W{1'b0}};
            valid_q <= {SETS{1'b0}};
            dirty_q <= {SETS{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            rtag_q  <= rtag_d;
            word_q  <= word_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            lbuf_q  <= lbuf_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            data_mem_q[idx_q] <= mem_line_s;
        end
        if (tag_we_s) begin
            tag_mem_q[idx_q] <= rtag_q;
        end
    end

    assign bus.cpu_addr_ack_o = addr_ack_s;
    assign bus.cpu_data_ack_o = data_ack_s;
    assign bus.cpu_rd_data_o  = rd_data_s;
    assign bus.ram_rd_req_o   = rd_req_s;
    assign bus.ram_rd_addr_o  = rd_addr_s;
    assign bus.ram_wr_req_o   = wr_req_s;
    assign bus.ram_wr_addr_o  = wr_addr_s;
    assign bus.ram_wr_data_o  = wr_data_s;
    assign bus.ram_dirty_o    = dirty_s;

`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Every request resolved in LOOKUP counts exactly once as a hit or a miss.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_LOOKUP) begin
            if (hit_s) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // Counter registers, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache.sv
// Randomized scoreboard bench for dcache: a CPU-visible memory model predicts read data,
// hits/misses and victim lines; a monitor pops expected responses on every data_ack.
`timescale 1ns/1ps
module tb_dcache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_if bus ();
`ifdef DCACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
    dcache dut (.clk(clk), .rst_n(rst_n), .bus(bus), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt));
`else
    dcache dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct { bit rd; logic [31:0] data; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference: RAM contents and CPU-visible memory, both keyed by word address.
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] view    [logic [31:0]];
    bit          m_valid [256];
    bit          m_dirty [256];
    logic [19:0] m_tag   [256];

    function automatic logic [31:0] ram_get(input logic [31:0] wa);
        if (ram_mem.exists(wa)) return ram_mem[wa];
        return (wa * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] view_get(input logic [31:0] wa);
        if (view.exists(wa)) return view[wa];
        return ram_get(wa);
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_quiet_outputs(input string nm);
        check({nm, "_ctl"}, {bus.cpu_addr_ack_o, bus.cpu_data_ack_o, bus.ram_rd_req_o,
                             bus.ram_wr_req_o, bus.ram_dirty_o}, 5'b0);
        check({nm, "_addr"}, {bus.cpu_rd_data_o, bus.ram_rd_addr_o, bus.ram_wr_addr_o}, 96'b0);
        check({nm, "_wdata"}, bus.ram_wr_data_o, 128'b0);
    endtask

    // Reset forgets the cache: dirty lines fall back to what RAM holds.
    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                for (int q = 0; q < 4; q++) view.delete({2'b00, m_tag[i], 8'(i), 2'(q)});
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Scoreboard monitor: every data_ack consumes one expected response.
    always @(negedge clk) begin
        if (rst_n && bus.cpu_data_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 1'b1, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.rd) check("rd_data", bus.cpu_rd_data_o, mon_e.data);
            end
        end
    end

    task automatic do_req(input bit op, input logic [7:0] idx, input logic [19:0] tag,
                          input logic [1:0] w, input logic [3:0] be, input logic [31:0] wd,
                          input int order_mode, input int wb_gap, input int abort_after);
        bit hit, wb, found, seen_wr, held, early;
        logic [31:0] line_wa, victim_wa;
        logic [127:0] vline;
        int order[4];
        exp_t e;
        line_wa = {2'b00, tag, idx, 2'b00};
        hit = m_valid[idx] && (m_tag[idx] == tag);
        wb  = !hit && m_valid[idx] && m_dirty[idx];
        @(posedge clk); #1;
        bus.cpu_op_i      = op;
        bus.cpu_index_i   = idx;
        bus.cpu_tag_i     = tag;
        bus.cpu_offset_i  = {w, 2'($urandom_range(0, 3))};
        bus.cpu_wr_en_i   = be;
        bus.cpu_wr_data_i = wd;
        bus.cpu_req_i     = 1'b1;
        @(negedge clk);
        check("addr_ack", bus.cpu_addr_ack_o, 1'b1);
        e.rd = !op;
        e.data = view_get(line_wa + 32'(w));
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
        if (hit) begin
            @(negedge clk);
            check("hit_ack", {bus.cpu_data_ack_o, bus.ram_rd_req_o, bus.ram_wr_req_o}, 3'b100);
        end else begin
            if (wb) begin
                found = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (bus.ram_wr_req_o) begin found = 1'b1; break; end
                end
                check("wb_seen", found, 1'b1);
                victim_wa = {2'b00, m_tag[idx], idx, 2'b00};
                for (int q = 0; q < 4; q++) vline[q*32 +: 32] = view_get(victim_wa + 32'(q));
                check("wb_addr", bus.ram_wr_addr_o, victim_wa << 2);
                check("wb_data", bus.ram_wr_data_o, vline);
                check("wb_dirty", bus.ram_dirty_o, 1'b1);
                held = 1'b1;
                repeat ((wb_gap < 0) ? $urandom_range(0, 3) : wb_gap) begin
                    @(negedge clk);
                    if (!(bus.ram_wr_req_o && bus.ram_dirty_o && bus.ram_wr_addr_o == (victim_wa << 2)
                          && bus.ram_wr_data_o == vline)) held = 1'b0;
                end
                check("wb_hold", held, 1'b1);
                bus.ram_wr_rdy_i = 1'b1;
                @(negedge clk);
                bus.ram_wr_rdy_i = 1'b0;
                for (int q = 0; q < 4; q++) ram_mem[victim_wa + 32'(q)] = vline[q*32 +: 32];
                m_dirty[idx] = 1'b0;
            end
            found = 1'b0;
            seen_wr = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.ram_rd_req_o) begin found = 1'b1; break; end
                if (bus.ram_wr_req_o) seen_wr = 1'b1;
            end
            check("rf_seen", found, 1'b1);
            if (!wb) check("clean_no_wb", seen_wr, 1'b0);
            check("rf_addr", bus.ram_rd_addr_o, line_wa << 2);
            order = '{0, 1, 2, 3};
            if (order_mode == 1) order = '{2, 0, 1, 3};
            if (order_mode == 2) begin
                for (int i = 2; i > 0; i--) begin
                    int j, t;
                    j = $urandom_range(0, i);
                    t = order[i]; order[i] = order[j]; order[j] = t;
                end
            end
            early = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (i == abort_after) begin
                    rst_n = 1'b0;
                    #1;
                    check_quiet_outputs("abort");
                    exp_q.delete();
                    model_reset();
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    if (bus.cpu_data_ack_o || !bus.ram_rd_req_o) early = 1'b1;
                end
                bus.ram_rd_rdy_i  = 1'b1;
                bus.ram_rd_num_i  = {1'($urandom_range(0, 1)), 2'(order[i])};
                bus.ram_rd_data_i = ram_get(line_wa + 32'(order[i]));
                @(negedge clk);
                bus.ram_rd_rdy_i  = 1'b0;
                if (i < 3 && (bus.cpu_data_ack_o || !bus.ram_rd_req_o)) early = 1'b1;
            end
            check("refill_seq", early, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("ack_drain", exp_q.size(), 0);
        exp_q.delete();
        if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (op) begin
            logic [31:0] old;
            old = view_get(line_wa + 32'(w));
            for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = wd[b*8 +: 8];
            view[line_wa + 32'(w)] = old;
            m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        bus.cpu_req_i = 1'b0; bus.cpu_op_i = 1'b0; bus.cpu_index_i = 8'd0; bus.cpu_tag_i = 20'd0;
        bus.cpu_offset_i = 4'd0; bus.cpu_wr_en_i = 4'd0; bus.cpu_wr_data_i = 32'd0;
        bus.ram_rd_rdy_i = 1'b0; bus.ram_rd_data_i = 32'd0; bus.ram_rd_num_i = 3'd0;
        bus.ram_wr_rdy_i = 1'b0;
        for (int i = 0; i < 256; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 20'd0; end
        repeat (3) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        ram_mem[32'd0] = 32'h11111111;
        ram_mem[32'd1] = 32'h22222222;
        ram_mem[32'd2] = 32'h33333333;
        ram_mem[32'd3] = 32'h44444444;
        // Cold read, read hit, write hit, read-after-write on set 0.
        do_req(1'b0, 8'd0, 20'd0, 2'd0, 4'b0000, 32'd0, 0, -1, -1);
        do_req(1'b0, 8'd0, 20'd0, 2'd1, 4'b0000, 32'd0, 0, -1, -1);
        do_req(1'b1, 8'd0, 20'd0, 2'd0, 4'b0011, 32'hAABBCCDD, 0, -1, -1);
        do_req(1'b0, 8'd0, 20'd0, 2'd0, 4'b0000, 32'd0, 0, -1, -1);
        check("model_merge", view_get(32'd0), 32'h1111CCDD);
        // Dirty eviction with a slow RAM, then out-of-order refill.
        do_req(1'b0, 8'd0, 20'h00001, 2'd2, 4'b0000, 32'd0, 1, 3, -1);
        check("wb_ram_word0", ram_get(32'd0), 32'h1111CCDD);
        // Reset in the middle of a refill, then the same line must miss again.
        do_req(1'b0, 8'd5, 20'h00007, 2'd1, 4'b0000, 32'd0, 0, -1, 2);
        do_req(1'b0, 8'd5, 20'h00007, 2'd1, 4'b0000, 32'd0, 2, -1, -1);
        // Random traffic over a few sets and tags to mix hits, misses and evictions.
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)), 20'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom, 2, -1,
                   (n % 60 == 59) ? $urandom_range(0, 3) : -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
